cic_multichannel_decimator: RTL and testbench

// Parametrised N-channel CIC decimator for the DSBPM turn-by-turn to FA/SA chain.

---
 rtl/dsbpm_pkg.sv | 23 ++
 rtl/cic_channel_core.sv | 73 +++++++
 rtl/cic_multichannel_decimator.sv | 122 ++++++++++++
 tb/tb_cic_multichannel_decimator.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/dsbpm_pkg.sv
// Shared constants and width helpers for the DSBPM CIC decimation chain.
package dsbpm_pkg;

  localparam int CIC_MAX_STAGES  = 4;
  localparam int FA_MAX_DECIMATE = 100;
  localparam int SA_MAX_DECIMATE = 2000;

  // Integrator/comb width that keeps a STAGES-deep CIC exact up to max_dec.
  function automatic int cic_full_width(input int in_w, input int stages, input int max_dec);
    return in_w + stages * $clog2(max_dec);
  endfunction

  // Width needed to hold a decimation ratio in 0..max_dec.
  function automatic int cic_dw(input int max_dec);
    return $clog2(max_dec + 1);
  endfunction

  // Default ratio ceiling for the FA (fast acquisition) or SA (slow acquisition) instance.
  function automatic int default_max_decimate(input bit is_sa);
    return is_sa ? SA_MAX_DECIMATE : FA_MAX_DECIMATE;
  endfunction

endpackage

// File: rtl/cic_channel_core.sv
// Single-channel CIC datapath: integrator cascade plus registered comb chain.
module cic_channel_core
  import dsbpm_pkg::*;
#(
  parameter int INPUT_WIDTH  = 26,
  parameter int FULL_WIDTH   = 48,
  parameter int OUTPUT_WIDTH = 32,
  parameter int STAGES       = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  input  logic                           sample_en,
  input  logic                           clear_delays,
  input  logic [STAGES-1:0]              stage_en,
  input  logic signed [INPUT_WIDTH-1:0]  in_sample,
  output logic signed [OUTPUT_WIDTH-1:0] out_sample
);

  localparam int SHIFT = FULL_WIDTH - OUTPUT_WIDTH;

  logic signed [FULL_WIDTH-1:0] integ    [STAGES];
  logic signed [FULL_WIDTH-1:0] sample_q;
  logic signed [FULL_WIDTH-1:0] comb_d   [STAGES];
  logic signed [FULL_WIDTH-1:0] comb_q   [STAGES];
  logic signed [FULL_WIDTH-1:0] stage_in [STAGES];

  // Integrator cascade, modular arithmetic, advancing only on input strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) integ[k] <= '0;
    end else if (in_valid) begin
      integ[0] <= integ[0] + FULL_WIDTH'(in_sample);
      for (int k = 1; k < STAGES; k++) integ[k] <= integ[k] + integ[k-1];
    end
  end

  // Capture the last integrator on each decimation tick to start the comb chain.
  always_ff @(posedge clk) begin
    if (reset) sample_q <= '0;
    else if (sample_en) sample_q <= integ[STAGES-1];
  end

  // Input of each comb stage: the captured sample for the first, the previous stage otherwise.
  always_comb begin
    for (int k = 0; k < STAGES; k++) stage_in[k] = '0;
    stage_in[0] = sample_q;
    for (int k = 1; k < STAGES; k++) stage_in[k] = comb_q[k-1];
  end

  // Comb chain, one stage per cycle; a realign wipes the delay lines but keeps the integrators.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) begin
        comb_d[k] <= '0;
        comb_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (stage_en[k]) begin
          comb_d[k] <= stage_in[k];
          comb_q[k] <= stage_in[k] - comb_d[k];
        end
      end
      if (clear_delays) begin
        for (int k = 0; k < STAGES; k++) comb_d[k] <= '0;
      end
    end
  end

  assign out_sample = OUTPUT_WIDTH'(comb_q[STAGES-1] >>> SHIFT);

endmodule

// File: rtl/cic_multichannel_decimator.sv
// N-channel CIC decimator with programmable ratio, sync realign and warm-up suppression.
module cic_multichannel_decimator
  import dsbpm_pkg::*;
#(
  parameter int CHANNEL_COUNT  = 8,
  parameter int INPUT_WIDTH    = 26,
  parameter int OUTPUT_WIDTH   = 32,
  parameter int MAX_DECIMATE   = 2000,
  parameter int STAGES         = 2,
  localparam int FULL_WIDTH    = cic_full_width(INPUT_WIDTH, STAGES, MAX_DECIMATE),
  localparam int DW            = cic_dw(MAX_DECIMATE)
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [DW-1:0]                          decimateFactor,
  input  logic                                   sync,
  input  logic                                   inValid,
  input  logic [CHANNEL_COUNT*INPUT_WIDTH-1:0]   inData,
  output logic                                   outValid,
  output logic                                   outFirst,
  output logic [CHANNEL_COUNT*OUTPUT_WIDTH-1:0]  outData
);

  localparam int WARM_W = $clog2(STAGES + 2);
  localparam logic [DW-1:0]     MAX_D     = DW'(MAX_DECIMATE);
  localparam logic [WARM_W-1:0] WARM_DONE = WARM_W'(STAGES);

  if (STAGES < 1 || STAGES > CIC_MAX_STAGES) begin : g_bad_stages
    $error("STAGES out of range");
  end
  if (OUTPUT_WIDTH > FULL_WIDTH) begin : g_bad_width
    $error("OUTPUT_WIDTH exceeds FULL_WIDTH");
  end

  logic [DW-1:0]     d_clamped;
  logic [DW-1:0]     d_act;
  logic [DW-1:0]     d_eff;
  logic [DW-1:0]     phase_cnt;
  logic [DW-1:0]     cnt_base;
  logic [WARM_W-1:0] warm_cnt;
  logic [WARM_W-1:0] warm_base;
  logic              tick;
  logic              tick_emit;
  logic              tick_first;
  logic [STAGES:0]   vpipe;
  logic [STAGES:0]   emit_pipe;
  logic [STAGES:0]   first_pipe;
  logic [STAGES-1:0] stage_en;

  // Clamp the requested ratio into 1..MAX_DECIMATE.
  always_comb begin
    d_clamped = decimateFactor;
    if (decimateFactor == '0) d_clamped = DW'(1);
    else if (decimateFactor > MAX_D) d_clamped = MAX_D;
  end

  // Tick decode; a sync cycle behaves as phase 0 of a fresh block with a fresh ratio and warm-up.
  always_comb begin
    cnt_base   = sync ? '0 : phase_cnt;
    d_eff      = sync ? d_clamped : d_act;
    warm_base  = sync ? '0 : warm_cnt;
    tick       = inValid && (cnt_base == d_eff - DW'(1));
    tick_emit  = (warm_base >= WARM_DONE);
    tick_first = (warm_base == WARM_DONE);
  end

  // Ratio latch, phase counter and saturating warm-up counter shared by all channels.
  always_ff @(posedge clk) begin
    if (reset) begin
      d_act     <= d_clamped;
      phase_cnt <= '0;
      warm_cnt  <= '0;
    end else begin
      if (sync || tick) d_act <= d_clamped;
      if (inValid) phase_cnt <= tick ? '0 : cnt_base + DW'(1);
      else if (sync) phase_cnt <= '0;
      if (tick && warm_base <= WARM_DONE) warm_cnt <= warm_base + WARM_W'(1);
      else if (sync) warm_cnt <= '0;
    end
  end

  // Valid/first tags travel alongside the comb chain; a sync drops anything already in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      vpipe      <= '0;
      emit_pipe  <= '0;
      first_pipe <= '0;
    end else begin
      vpipe[0]      <= tick;
      emit_pipe[0]  <= tick_emit;
      first_pipe[0] <= tick_first;
      for (int k = 1; k <= STAGES; k++) begin
        vpipe[k]      <= vpipe[k-1] & ~sync;
        emit_pipe[k]  <= emit_pipe[k-1];
        first_pipe[k] <= first_pipe[k-1];
      end
    end
  end

  assign stage_en = vpipe[STAGES-1:0] & ~{STAGES{sync}};
  assign outValid = vpipe[STAGES] & emit_pipe[STAGES];
  assign outFirst = vpipe[STAGES] & first_pipe[STAGES];

  for (genvar ch = 0; ch < CHANNEL_COUNT; ch++) begin : g_channel
    cic_channel_core #(
      .INPUT_WIDTH  (INPUT_WIDTH),
      .FULL_WIDTH   (FULL_WIDTH),
      .OUTPUT_WIDTH (OUTPUT_WIDTH),
      .STAGES       (STAGES)
    ) u_core (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (inValid),
      .sample_en    (tick),
      .clear_delays (sync),
      .stage_en     (stage_en),
      .in_sample    (inData[ch*INPUT_WIDTH +: INPUT_WIDTH]),
      .out_sample   (outData[ch*OUTPUT_WIDTH +: OUTPUT_WIDTH])
    );
  end

endmodule

// File: tb/tb_cic_multichannel_decimator.sv
// Directed bench for cic_multichannel_decimator with hand-computed expectations.
module tb_cic_multichannel_decimator;

  localparam int CH   = 8;
  localparam int IW   = 26;
  localparam int OW   = 32;
  localparam int MAXD = 2000;
  localparam int ST   = 2;
  localparam int DW   = 11;

  logic               clk = 1'b0;
  logic               reset;
  logic               sync;
  logic               inValid;
  logic [DW-1:0]      decimateFactor;
  logic [CH*IW-1:0]   inData;
  logic               outValid;
  logic               outFirst;
  logic [CH*OW-1:0]   outData;

  int n_checks = 0;
  int n_passed = 0;

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  cic_multichannel_decimator #(
    .CHANNEL_COUNT (CH),
    .INPUT_WIDTH   (IW),
    .OUTPUT_WIDTH  (OW),
    .MAX_DECIMATE  (MAXD),
    .STAGES        (ST)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .decimateFactor (decimateFactor),
    .sync           (sync),
    .inValid        (inValid),
    .inData         (inData),
    .outValid       (outValid),
    .outFirst       (outFirst),
    .outData        (outData)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input longint actual, input longint expected);
    n_checks++;
    if (actual == expected) n_passed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
  endtask

  function automatic longint ch_out(input int k);
    return longint'($signed(outData[k*OW +: OW]));
  endfunction

  task automatic applyStimulus(input logic valid, input logic sync_v);
    inValid = valid;
    sync    = sync_v;
  endtask

  task automatic set_const(input int v);
    for (int k = 0; k < CH; k++) inData[k*IW +: IW] = IW'(v);
  endtask

  task automatic do_reset(input int d);
    decimateFactor = DW'(d);
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0);
    step();
    step();
    reset = 1'b0;
  endtask

  // Step until outValid is seen or the budget runs out; n is the number of clock edges taken.
  task automatic wait_valid(input int max_cycles, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!outValid && n < max_cycles);
  endtask

  initial begin
    int n;
    set_const(0);
    decimateFactor = DW'(100);
    applyStimulus(1'b0, 1'b0);
    reset = 1'b1;
    step();
    checkOutput("reset_valid", longint'(outValid), 0);
    checkOutput("reset_first", longint'(outFirst), 0);
    checkOutput("reset_data", ch_out(0), 0);

    // Constant gain, D=100
    $display("[TB] constant gain D=100");
    do_reset(100);
    set_const(1000);
    applyStimulus(1'b1, 1'b0);
    wait_valid(400, n);
    checkOutput("gain_first_latency", n, 302);
    checkOutput("gain_first_flag", longint'(outFirst), 1);
    for (int k = 0; k < CH; k++) checkOutput($sformatf("gain_ch%0d", k), ch_out(k), 152);
    step();
    checkOutput("gain_pulse_width", longint'(outValid), 0);
    wait_valid(200, n);
    checkOutput("gain_spacing", n + 1, 100);
    checkOutput("gain_second_flag", longint'(outFirst), 0);
    checkOutput("gain_second_data", ch_out(3), 152);

    // Sign and packing, D=1
    $display("[TB] sign/packing D=1");
    do_reset(1);
    for (int k = 0; k < CH; k++) inData[k*IW +: IW] = IW'(-(k + 1) * 65536);
    applyStimulus(1'b1, 1'b0);
    wait_valid(20, n);
    checkOutput("d1_latency", n, 5);
    checkOutput("d1_first_flag", longint'(outFirst), 1);
    for (int k = 0; k < CH; k++) checkOutput($sformatf("d1_ch%0d", k), ch_out(k), -(k + 1));
    step();
    checkOutput("d1_back_to_back", longint'(outValid), 1);
    checkOutput("d1_second_flag", longint'(outFirst), 0);
    checkOutput("d1_second_ch7", ch_out(7), -8);

    // Ratio change mid-block: 100 -> 50 at counter 40
    $display("[TB] ratio change");
    do_reset(100);
    set_const(1000);
    applyStimulus(1'b1, 1'b0);
    wait_valid(400, n);
    checkOutput("ratio_first_latency", n, 302);
    for (int i = 0; i < 38; i++) step();
    decimateFactor = DW'(50);
    wait_valid(200, n);
    checkOutput("ratio_block_closes", n, 62);
    wait_valid(200, n);
    checkOutput("ratio_new_spacing", n, 50);
    wait_valid(200, n);
    checkOutput("ratio_new_spacing2", n, 50);
    checkOutput("ratio_new_data", ch_out(0), 38);

    // Clamp: 0 acts as 1, 4095 acts as 2000
    $display("[TB] clamp");
    do_reset(0);
    set_const(1000);
    applyStimulus(1'b1, 1'b0);
    wait_valid(20, n);
    checkOutput("clamp_zero_latency", n, 5);
    checkOutput("clamp_zero_data", ch_out(0), 0);
    do_reset(4095);
    applyStimulus(1'b1, 1'b0);
    wait_valid(7000, n);
    checkOutput("clamp_max_latency", n, 6002);
    checkOutput("clamp_max_data", ch_out(2), 61035);
    wait_valid(2500, n);
    checkOutput("clamp_max_spacing", n, 2000);

    // Sync drops an in-flight output and restarts warm-up
    $display("[TB] sync");
    do_reset(100);
    set_const(1000);
    applyStimulus(1'b1, 1'b0);
    wait_valid(400, n);
    for (int i = 0; i < 98; i++) step();
    applyStimulus(1'b1, 1'b1);
    step();
    applyStimulus(1'b1, 1'b0);
    wait_valid(400, n);
    checkOutput("sync_drop_latency", n + 1, 302);
    checkOutput("sync_drop_first", longint'(outFirst), 1);
    checkOutput("sync_drop_data", ch_out(5), 152);
    for (int i = 0; i < 35; i++) step();
    applyStimulus(1'b1, 1'b1);
    step();
    applyStimulus(1'b1, 1'b0);
    wait_valid(400, n);
    checkOutput("sync_mid_latency", n + 1, 302);
    checkOutput("sync_mid_first", longint'(outFirst), 1);
    checkOutput("sync_mid_data", ch_out(1), 152);

    // Reset while a tick is inside the comb chain
    $display("[TB] reset mid-operation");
    for (int i = 0; i < 98; i++) step();
    reset = 1'b1;
    step();
    checkOutput("midreset_valid", longint'(outValid), 0);
    checkOutput("midreset_first", longint'(outFirst), 0);
    checkOutput("midreset_data0", ch_out(0), 0);
    checkOutput("midreset_data6", ch_out(6), 0);
    reset = 1'b0;
    wait_valid(400, n);
    checkOutput("midreset_relatency", n, 302);
    checkOutput("midreset_first_after", longint'(outFirst), 1);
    checkOutput("midreset_data_after", ch_out(4), 152);

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
